seg7_capture: RTL and testbench

- Reader for the board's active-low seven-segment drive.
- Samples a time-multiplexed segment bus (shared segment pattern plus one-hot digit select). Recovers the hex nibble shown on each digit, and flags blanks and unrecognised patterns.
- Used in loop-back self-test of display drivers and for scraping display output from external boards into the logic analyser path.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_inv.sv | 44 ++++
 rtl/seg7_capture.sv | 158 +++++++++++++++
 tb/tb_seg7_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment capture path.
// Segment patterns are active-low with bit0=a through bit6=g.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h18;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_D     = 7'h21;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_F     = 7'h0E;
    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg7_inv.sv
// Combinational inverse of the standard active-low hex encoding.
// Reports the recovered nibble, whether the pattern is a legal hex glyph,
// and whether the pattern is the all-off blank.
module seg7_inv
    import seg7_pkg::*;
(
    input  seg_t       i_seg,
    output logic [3:0] o_nibble,
    output logic       o_legal,
    output logic       o_blank
);

    // Table lookup; anything outside the sixteen glyphs is not legal,
    // and the blank pattern is flagged separately from other illegal ones.
    always_comb begin
        o_nibble = 4'h0;
        o_legal  = 1'b1;
        o_blank  = 1'b0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Reader for a time-multiplexed active-low seven-segment bus.
// Waits for the segment/select pair to be stable for STABLE_CYC samples,
// evaluates it exactly once, and records the recovered digit.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NDIG       = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              segs_in,
    input  logic [NDIG-1:0]         dig_sel,
    output logic [4*NDIG-1:0]       digits,
    output logic [NDIG-1:0]         digit_valid,
    output logic [NDIG-1:0]         digit_blank,
    output logic                    upd,
    output logic [$clog2(NDIG)-1:0] upd_idx,
    output logic                    err,
    output logic                    frame_done
);

    localparam int IDXW = $clog2(NDIG);
    localparam int SW   = 7 + NDIG;

    logic [SW-1:0]     r_samp;
    logic [SW-1:0]     r_sampD;
    logic [7:0]        r_cnt;
    cap_state_t        r_state;
    logic [NDIG-1:0]   r_frameMask;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_valid;
    logic [NDIG-1:0]   r_blank;
    logic              r_upd;
    logic [IDXW-1:0]   r_updIdx;
    logic              r_err;
    logic              r_frameDone;

    seg_t              w_sampSeg;
    logic [NDIG-1:0]   w_sampSel;
    logic              w_stable;
    logic [3:0]        w_nibble;
    logic              w_legal;
    logic              w_blank;
    logic [IDXW-1:0]   w_selIdx;
    logic [NDIG-1:0]   w_maskNext;

    assign w_sampSeg  = r_samp[NDIG +: 7];
    assign w_sampSel  = r_samp[NDIG-1:0];
    assign w_stable   = (r_samp == r_sampD);
    assign w_maskNext = r_frameMask | (NDIG'(1) << w_selIdx);

    seg7_inv u_inv (
        .i_seg    (w_sampSeg),
        .o_nibble (w_nibble),
        .o_legal  (w_legal),
        .o_blank  (w_blank)
    );

    // Binary index of the selected digit; only meaningful when the select is one-hot.
    always_comb begin
        w_selIdx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_sampSel[i]) begin
                w_selIdx = IDXW'(i);
            end
        end
    end

    // Register the bus every cycle and count how long it has stayed unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp  <= '0;
            r_sampD <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_samp  <= {segs_in, dig_sel};
            r_sampD <= r_samp;
            if (!w_stable) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // One evaluation per stable period: WAIT until stable long enough, EVAL once,
    // then HOLD until the bus moves. If the bus already moved during EVAL we go
    // straight back to WAIT so the new value is not missed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT;
            r_frameMask <= '0;
            r_digits    <= '0;
            r_valid     <= '0;
            r_blank     <= '0;
            r_upd       <= 1'b0;
            r_updIdx    <= '0;
            r_err       <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_upd       <= 1'b0;
            r_err       <= 1'b0;
            r_frameDone <= 1'b0;
            case (r_state)
                WAIT: begin
                    if (w_stable && (r_cnt == 8'(STABLE_CYC - 2))) begin
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    r_state <= w_stable ? HOLD : WAIT;
                    if (w_sampSel != '0) begin
                        if (!$onehot(w_sampSel)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_upd    <= 1'b1;
                            r_updIdx <= w_selIdx;
                            if (w_legal) begin
                                r_digits[4*w_selIdx +: 4] <= w_nibble;
                                r_valid[w_selIdx]         <= 1'b1;
                                r_blank[w_selIdx]         <= 1'b0;
                            end else if (w_blank) begin
                                r_valid[w_selIdx] <= 1'b0;
                                r_blank[w_selIdx] <= 1'b1;
                            end else begin
                                r_err             <= 1'b1;
                                r_valid[w_selIdx] <= 1'b0;
                                r_blank[w_selIdx] <= 1'b0;
                            end
                            if (&w_maskNext) begin
                                r_frameDone <= 1'b1;
                                r_frameMask <= '0;
                            end else begin
                                r_frameMask <= w_maskNext;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!w_stable) begin
                        r_state <= WAIT;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign digit_blank = r_blank;
    assign upd         = r_upd;
    assign upd_idx     = r_updIdx;
    assign err         = r_err;
    assign frame_done  = r_frameDone;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with hand-computed expectations.
// Edge numbering: edge 0 is the first rising edge that registers a new input.
module tb_seg7_capture;

    logic        clk;
    logic        reset;
    logic [6:0]  segsIn;
    logic [5:0]  digSel;
    logic [23:0] digits;
    logic [5:0]  digitValid;
    logic [5:0]  digitBlank;
    logic        upd;
    logic [2:0]  updIdx;
    logic        err;
    logic        frameDone;

    int vecCount  = 0;
    int missCount = 0;
    int uc, ue, ec, ee, fc, fe;

    seg7_capture #(.NDIG(6), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .segs_in     (segsIn),
        .dig_sel     (digSel),
        .digits      (digits),
        .digit_valid (digitValid),
        .digit_blank (digitBlank),
        .upd         (upd),
        .upd_idx     (updIdx),
        .err         (err),
        .frame_done  (frameDone)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold one bus value for nEdges edges, recording pulse counts and the edge of the last pulse.
    task automatic applyStimulus(input logic [6:0] seg, input logic [5:0] sel, input int nEdges,
                                 output int updCnt, output int updEdge,
                                 output int errCnt, output int errEdge,
                                 output int frCnt, output int frEdge);
        updCnt = 0; updEdge = -1;
        errCnt = 0; errEdge = -1;
        frCnt  = 0; frEdge  = -1;
        segsIn = seg;
        digSel = sel;
        for (int e = 0; e < nEdges; e++) begin
            tick();
            if (upd === 1'b1)       begin updCnt++; updEdge = e; end
            if (err === 1'b1)       begin errCnt++; errEdge = e; end
            if (frameDone === 1'b1) begin frCnt++;  frEdge  = e; end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_digits"}, {8'd0, digits}, 32'h0);
        checkOutput({tag, "_valid"}, {26'd0, digitValid}, 32'h0);
        checkOutput({tag, "_blank"}, {26'd0, digitBlank}, 32'h0);
        checkOutput({tag, "_upd"}, {31'd0, upd}, 32'h0);
        checkOutput({tag, "_updIdx"}, {29'd0, updIdx}, 32'h0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'h0);
        checkOutput({tag, "_frame"}, {31'd0, frameDone}, 32'h0);
    endtask

    logic [6:0] scan1 [6];
    logic [6:0] scan2 [6];

    initial begin
        scan1 = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        scan2 = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        reset  = 1'b1;
        segsIn = 7'h00;
        digSel = 6'b0;
        repeat (3) tick();
        checkAllZero("rst");
        reset = 1'b0;

        applyStimulus(7'h30, 6'b000100, 10, uc, ue, ec, ee, fc, fe);
        checkOutput("t1_updCnt", uc, 1);
        checkOutput("t1_updEdge", ue, 5);
        checkOutput("t1_updIdx", {29'd0, updIdx}, 2);
        checkOutput("t1_digits", {8'd0, digits}, 32'h000300);
        checkOutput("t1_valid", {26'd0, digitValid}, 32'h04);
        checkOutput("t1_errCnt", ec, 0);
        checkOutput("t1_frameCnt", fc, 0);

        applyStimulus(7'h7F, 6'b000000, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("idle_updCnt", uc, 0);
        checkOutput("idle_errCnt", ec, 0);

        applyStimulus(7'h30, 6'b000100, 3, uc, ue, ec, ee, fc, fe);
        checkOutput("gl_pre_updCnt", uc, 0);
        applyStimulus(7'h00, 6'b000100, 1, uc, ue, ec, ee, fc, fe);
        checkOutput("gl_glitch_updCnt", uc, 0);
        applyStimulus(7'h30, 6'b000100, 10, uc, ue, ec, ee, fc, fe);
        checkOutput("gl_updCnt", uc, 1);
        checkOutput("gl_updEdge", ue, 5);
        checkOutput("gl_digits", {8'd0, digits}, 32'h000300);
        checkOutput("gl_errCnt", ec, 0);

        applyStimulus(7'h7F, 6'b000001, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("blk_updCnt", uc, 1);
        checkOutput("blk_updEdge", ue, 5);
        checkOutput("blk_updIdx", {29'd0, updIdx}, 0);
        checkOutput("blk_blank", {26'd0, digitBlank}, 32'h01);
        checkOutput("blk_errCnt", ec, 0);
        checkOutput("blk_digits", {8'd0, digits}, 32'h000300);

        applyStimulus(7'h55, 6'b000010, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("bad_updCnt", uc, 1);
        checkOutput("bad_errCnt", ec, 1);
        checkOutput("bad_errEdge", ee, 5);
        checkOutput("bad_updIdx", {29'd0, updIdx}, 1);
        checkOutput("bad_valid", {26'd0, digitValid}, 32'h04);
        checkOutput("bad_blank", {26'd0, digitBlank}, 32'h01);
        checkOutput("bad_digits", {8'd0, digits}, 32'h000300);

        applyStimulus(7'h40, 6'b000011, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("multi_errCnt", ec, 1);
        checkOutput("multi_updCnt", uc, 0);
        checkOutput("multi_digits", {8'd0, digits}, 32'h000300);
        checkOutput("multi_valid", {26'd0, digitValid}, 32'h04);
        checkOutput("multi_blank", {26'd0, digitBlank}, 32'h01);

        applyStimulus(7'h40, 6'b000000, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("sel0_updCnt", uc, 0);
        checkOutput("sel0_errCnt", ec, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(scan1[i], 6'(1 << i), 6, uc, ue, ec, ee, fc, fe);
            checkOutput($sformatf("scan1_updCnt%0d", i), uc, 1);
            checkOutput($sformatf("scan1_updEdge%0d", i), ue, 5);
            checkOutput($sformatf("scan1_frameCnt%0d", i), fc, (i == 5) ? 1 : 0);
            if (i == 5) begin
                checkOutput("scan1_frameEdge", fe, 5);
            end
        end
        checkOutput("scan1_digits", {8'd0, digits}, 32'h654321);
        checkOutput("scan1_valid", {26'd0, digitValid}, 32'h3F);
        checkOutput("scan1_blank", {26'd0, digitBlank}, 32'h00);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(scan2[i], 6'(1 << i), 6, uc, ue, ec, ee, fc, fe);
            checkOutput($sformatf("scan2_updCnt%0d", i), uc, 1);
            checkOutput($sformatf("scan2_frameCnt%0d", i), fc, (i == 5) ? 1 : 0);
            checkOutput($sformatf("scan2_errCnt%0d", i), ec, 0);
        end
        checkOutput("scan2_digits", {8'd0, digits}, 32'hFEDCBA);

        applyStimulus(7'h18, 6'b001000, 3, uc, ue, ec, ee, fc, fe);
        checkOutput("rs_pre_updCnt", uc, 0);
        reset = 1'b1;
        tick();
        checkAllZero("rs_mid");
        tick();
        reset = 1'b0;
        applyStimulus(7'h18, 6'b001000, 10, uc, ue, ec, ee, fc, fe);
        checkOutput("rs_updCnt", uc, 1);
        checkOutput("rs_updEdge", ue, 5);
        checkOutput("rs_digits", {8'd0, digits}, 32'h009000);
        checkOutput("rs_valid", {26'd0, digitValid}, 32'h08);
        checkOutput("rs_errCnt", ec, 0);

        applyStimulus(7'h78, 6'b010000, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("d7_digits", {8'd0, digits}, 32'h079000);
        applyStimulus(7'h00, 6'b100000, 8, uc, ue, ec, ee, fc, fe);
        checkOutput("d8_digits", {8'd0, digits}, 32'h879000);
        checkOutput("d8_valid", {26'd0, digitValid}, 32'h38);
        checkOutput("d8_frameCnt", fc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
